// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and lane helpers for the MEM-stage data-memory access controller.
// Pure combinational functions; no state, no flow control.
package mem_acc_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Size 2'b11 falls through to word in every helper.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return ~addr_lo[0];
      default: return addr_lo == 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 4'b0001 << addr_lo;
      SZ_H:    return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ld_extract(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] addr_lo, input logic is_unsigned);
    logic [31:0] sh;
    sh = word >> {addr_lo, 3'b000};
    case (size)
      SZ_B:    return {{24{~is_unsigned & sh[7]}}, sh[7:0]};
      SZ_H:    return {{16{~is_unsigned & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_fmt.sv
// Store-lane replication / byte-enable generation and load lane extraction.
// Purely combinational, zero latency, no backpressure.
module mem_fmt
  import mem_acc_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata_in,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data
);

  always_comb begin
    case (st_size)
      SZ_B:    st_wdata = {4{st_wdata_in[7:0]}};
      SZ_H:    st_wdata = {2{st_wdata_in[15:0]}};
      default: st_wdata = st_wdata_in;
    endcase
  end

  assign st_be   = be_gen(st_size, st_addr_lo);
  assign ld_data = ld_extract(ld_word, ld_size, ld_addr_lo, ld_unsigned);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer on a req/ack data port; stalls the pipe for 1 + BUSY cycles.
// Optional MEM_ACC_PERF_EN adds access and stall-cycle counters (outputs read 0 without it).
module mem_access_ctrl #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read_m,
  input  logic             mem_write_m,
  input  logic [1:0]       size_m,
  input  logic             ld_unsigned_m,
  input  logic [WIDTH-1:0] addr_m,
  input  logic [WIDTH-1:0] wdata_m,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic             dmem_ack,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [WIDTH-1:0] read_data_m,
  output logic             stall_pipe,
  output logic             mw_bubble,
  output logic             misaligned_m,
  output logic             bus_err_m,
  output logic [31:0]      perf_accesses,
  output logic [31:0]      perf_stall_cycles
);
  import mem_acc_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]       dmem_be_q, dmem_be_d;
  logic             dmem_we_q, dmem_we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       lo_q, lo_d;

  logic             access, aligned;
  logic [31:0]      st_wdata, ld_data;
  logic [3:0]       st_be;

  assign access  = mem_read_m | mem_write_m;
  assign aligned = is_aligned(size_m, addr_m[1:0]);

  // Store side formats the live request; load side uses the lane info latched at launch.
  mem_fmt u_fmt (
    .st_size     (size_m),
    .st_addr_lo  (addr_m[1:0]),
    .st_wdata_in (wdata_m),
    .st_wdata    (st_wdata),
    .st_be       (st_be),
    .ld_word     (dmem_rdata),
    .ld_size     (size_q),
    .ld_addr_lo  (lo_q),
    .ld_unsigned (uns_q),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    dmem_we_d    = dmem_we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lo_d         = lo_q;
    stall_pipe   = 1'b0;
    misaligned_m = 1'b0;
    bus_err_m    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            stall_pipe   = 1'b1;
            dmem_addr_d  = {addr_m[WIDTH-1:2], 2'b00};
            dmem_wdata_d = st_wdata;
            dmem_be_d    = st_be;
            dmem_we_d    = mem_write_m;
            size_d       = size_m;
            uns_d        = ld_unsigned_m;
            lo_d         = addr_m[1:0];
            state_d      = BUSY;
          end else begin
            misaligned_m = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_pipe = 1'b1;
        if (dmem_ack) begin
          rdata_d = ld_data;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        bus_err_m = err_q;
        cnt_d     = '0;
        err_d     = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_be_q    <= '0;
      dmem_we_q    <= 1'b0;
      size_q       <= SZ_W;
      uns_q        <= 1'b0;
      lo_q         <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      dmem_we_q    <= dmem_we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lo_q         <= lo_d;
    end
  end

  assign dmem_req    = (state_q == BUSY);
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign dmem_be     = dmem_be_q;
  assign read_data_m = rdata_q;
  assign mw_bubble   = stall_pipe;

`ifdef MEM_ACC_PERF_EN
  logic [31:0] perf_acc_q, perf_acc_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_acc_d   = perf_acc_q + {31'd0, (state_q == IDLE) && (state_d == BUSY)};
    perf_stall_d = perf_stall_q + {31'd0, stall_pipe};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_acc_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_acc_q   <= perf_acc_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_accesses     = perf_acc_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  assign perf_accesses     = 32'd0;
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a scoreboard of expected load results.
module tb_mem_access_ctrl;
  import mem_acc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_m, mem_write_m, ld_unsigned_m;
  logic [1:0]  size_m;
  logic [31:0] addr_m, wdata_m;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, read_data_m;
  logic [3:0]  dmem_be;
  logic        stall_pipe, mw_bubble, misaligned_m, bus_err_m;
  logic [31:0] perf_accesses, perf_stall_cycles;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          stalls;
    logic        chk_rd;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_acc = 0;
  int   exp_stall = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .size_m(size_m),
    .ld_unsigned_m(ld_unsigned_m), .addr_m(addr_m), .wdata_m(wdata_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .read_data_m(read_data_m), .stall_pipe(stall_pipe),
    .mw_bubble(mw_bubble), .misaligned_m(misaligned_m), .bus_err_m(bus_err_m),
    .perf_accesses(perf_accesses), .perf_stall_cycles(perf_stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drives one access, acks in BUSY cycle ack_at (0 = never), and checks it at DONE.
  task automatic do_access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdat,
                           input int ack_at, input logic [31:0] rdat,
                           input logic [31:0] e_addr, input logic [31:0] e_wdata,
                           input logic [3:0] e_be, input int e_stalls,
                           input logic chk_rd, input logic [31:0] e_rd, input logic e_err);
    exp_t e;
    int   busy;
    int   stalls;
    bit   done;
    e.rd = e_rd; e.err = e_err; e.stalls = e_stalls; e.chk_rd = chk_rd;
    @(posedge clk); #1;
    mem_read_m = rd; mem_write_m = wr; size_m = sz; ld_unsigned_m = uns;
    addr_m = addr; wdata_m = wdat;
    sb.push_back(e);
    exp_acc++;
    exp_stall += e_stalls;
    busy = 0; stalls = 0; done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (stall_pipe) stalls++;
      if (dmem_req) begin
        busy++;
        chkb({tag, "/bubble_busy"}, mw_bubble, 1'b1);
        if (busy == 1) begin
          chk({tag, "/addr"}, dmem_addr, e_addr);
          chk({tag, "/be"}, {28'd0, dmem_be}, {28'd0, e_be});
          chk({tag, "/wdata"}, dmem_wdata, e_wdata);
          chkb({tag, "/we"}, dmem_we, wr);
          chkb({tag, "/err_busy"}, bus_err_m, 1'b0);
        end
        if (busy == ack_at) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdat;
        end
      end else if (busy > 0) begin
        e = sb.pop_front();
        chkb({tag, "/bubble_done"}, mw_bubble, 1'b0);
        chk({tag, "/stalls"}, stalls, e.stalls);
        chkb({tag, "/bus_err"}, bus_err_m, e.err);
        if (e.chk_rd) chk({tag, "/rdata"}, read_data_m, e.rd);
        done = 1;
      end else begin
        chkb({tag, "/bubble_start"}, mw_bubble, 1'b1);
      end
    end
    chkb({tag, "/reached_done"}, done, 1'b1);
    @(posedge clk); #1;
    mem_read_m = 1'b0; mem_write_m = 1'b0;
    @(negedge clk);
    chkb({tag, "/err_after"}, bus_err_m, 1'b0);
  endtask

  initial begin
    rst = 1'b1; mem_read_m = 1'b0; mem_write_m = 1'b0; size_m = SZ_W; ld_unsigned_m = 1'b0;
    addr_m = '0; wdata_m = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chkb("rst/req", dmem_req, 1'b0);
    chkb("rst/we", dmem_we, 1'b0);
    chk("rst/be", {28'd0, dmem_be}, 32'd0);
    chk("rst/addr", dmem_addr, 32'd0);
    chk("rst/wdata", dmem_wdata, 32'd0);
    chk("rst/rdata", read_data_m, 32'd0);
    chkb("rst/stall", stall_pipe, 1'b0);

    do_access("lw", 1, 0, SZ_W, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF,
              32'h100, 32'h0, 4'b1111, 4, 1, 32'hDEADBEEF, 0);
    do_access("sb", 0, 1, SZ_B, 0, 32'h203, 32'h000000A5, 1, 32'h0,
              32'h200, 32'hA5A5A5A5, 4'b1000, 2, 0, 32'h0, 0);
    do_access("sh", 0, 1, SZ_H, 0, 32'h202, 32'hFFFF1234, 2, 32'h0,
              32'h200, 32'h12341234, 4'b1100, 3, 0, 32'h0, 0);
    do_access("lh", 1, 0, SZ_H, 0, 32'h102, 32'h0, 1, 32'h80010000,
              32'h100, 32'h0, 4'b1100, 2, 1, 32'hFFFF8001, 0);
    do_access("lhu", 1, 0, SZ_H, 1, 32'h102, 32'h0, 1, 32'h80010000,
              32'h100, 32'h0, 4'b1100, 2, 1, 32'h00008001, 0);
    do_access("lb", 1, 0, SZ_B, 0, 32'h301, 32'h0, 1, 32'h00008000,
              32'h300, 32'h0, 4'b0010, 2, 1, 32'hFFFFFF80, 0);

    @(posedge clk); #1;
    mem_read_m = 1'b1; size_m = SZ_W; addr_m = 32'h101;
    #1;
    chkb("mis/flag", misaligned_m, 1'b1);
    chkb("mis/stall", stall_pipe, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chkb("mis/req", dmem_req, 1'b0);
      chkb("mis/bubble", mw_bubble, 1'b0);
    end
    @(posedge clk); #1;
    mem_read_m = 1'b0;
    @(negedge clk);
    chkb("mis/clear", misaligned_m, 1'b0);

    do_access("tmo", 1, 0, SZ_W, 0, 32'h400, 32'h0, 0, 32'h0,
              32'h400, 32'h0, 4'b1111, 5, 1, 32'h0, 1);
    do_access("ack4", 1, 0, SZ_W, 0, 32'h404, 32'h0, 4, 32'h12345678,
              32'h404, 32'h0, 4'b1111, 5, 1, 32'h12345678, 0);

`ifdef MEM_ACC_PERF_EN
    chk("perf/acc", perf_accesses, 32'(exp_acc));
    chk("perf/stall", perf_stall_cycles, 32'(exp_stall));
`else
    chk("perf/acc", perf_accesses, 32'd0);
    chk("perf/stall", perf_stall_cycles, 32'd0);
`endif

    // Reset lands in the second BUSY cycle; the following ack must be ignored.
    @(posedge clk); #1;
    mem_read_m = 1'b1; size_m = SZ_W; addr_m = 32'h500;
    @(negedge clk);
    @(negedge clk);
    chkb("rbusy/req1", dmem_req, 1'b1);
    @(negedge clk);
    chkb("rbusy/req2", dmem_req, 1'b1);
    rst = 1'b1; mem_read_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chkb("rbusy/req_off", dmem_req, 1'b0);
    chk("rbusy/rdata", read_data_m, 32'd0);
    chkb("rbusy/stall", stall_pipe, 1'b0);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    dmem_ack = 1'b0;
    chkb("rbusy/late_req", dmem_req, 1'b0);
    chkb("rbusy/late_err", bus_err_m, 1'b0);
    chk("rbusy/late_rdata", read_data_m, 32'd0);
    chk("rbusy/perf_acc", perf_accesses, 32'd0);

    chk("sb/empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
